// File: rtl/updown_counter.sv
// Up/down counter over the range 0..max with clamped load, wrap or saturate at
// the bounds, a one-cycle terminal-count pulse and a sticky bound-crossing flag.
module updown_counter #(
   parameter int unsigned BUS_WIDTH = 8,
   parameter int unsigned SATURATE  = 0,
   parameter int unsigned STEP      = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 st,
   input  logic [BUS_WIDTH-1:0] X,
   input  logic                 en,
   input  logic                 dir,
   input  logic [BUS_WIDTH-1:0] max,
   input  logic                 clr_ovf,
   output logic [BUS_WIDTH-1:0] o,
   output logic                 tc,
   output logic                 ovf,
   output logic                 zero
);

   localparam logic [BUS_WIDTH:0] LP_STEP = (BUS_WIDTH+1)'(STEP);
   localparam bit                 LP_SAT  = (SATURATE != 0);

   logic [BUS_WIDTH-1:0] r_cnt;
   logic                 r_tc;
   logic                 r_ovf;

   logic [BUS_WIDTH:0]   w_sum;
   logic [BUS_WIDTH-1:0] w_diff;
   logic [BUS_WIDTH-1:0] w_load;
   logic                 w_up_bnd;
   logic                 w_dn_bnd;
   logic                 w_bnd;
   logic [BUS_WIDTH-1:0] w_next;

   // Sum kept one bit wider so an up step past 2^BUS_WIDTH-1 is still seen as > max.
   assign w_sum    = {1'b0, r_cnt} + LP_STEP;
   assign w_diff   = r_cnt - LP_STEP[BUS_WIDTH-1:0];
   assign w_up_bnd = (w_sum > {1'b0, max});
   assign w_dn_bnd = ({1'b0, r_cnt} < LP_STEP);
   assign w_load   = (X > max) ? max : X;
   assign w_bnd    = !st && en && (dir ? w_up_bnd : w_dn_bnd);

   always_comb begin
      w_next = r_cnt;
      if (st) begin
         w_next = w_load;
      end else if (en) begin
         if (dir) begin
            if (w_up_bnd) w_next = LP_SAT ? max : '0;
            else          w_next = w_sum[BUS_WIDTH-1:0];
         end else begin
            if (w_dn_bnd) w_next = LP_SAT ? '0 : max;
            else          w_next = w_diff;
         end
      end
   end

   // A boundary event on the same edge as clr_ovf leaves the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         r_cnt <= w_next;
         r_tc  <= w_bnd;
         r_ovf <= w_bnd | (r_ovf & ~clr_ovf);
      end
   end

   assign o    = r_cnt;
   assign tc   = r_tc;
   assign ovf  = r_ovf;
   assign zero = (r_cnt == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Drives three counter variants (wrap, saturate, step 3) with shared stimulus
// and compares each against an arithmetic model of the counting rules.
module tb_updown_counter;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         st = 1'b0;
   logic         en = 1'b0;
   logic         dir = 1'b0;
   logic         clr_ovf = 1'b0;
   logic [W-1:0] X = '0;
   logic [W-1:0] mx = '0;

   logic [W-1:0] o_q    [3];
   logic         tc_q   [3];
   logic         ovf_q  [3];
   logic         zero_q [3];

   int unsigned  p_sat  [3] = '{0, 1, 0};
   int unsigned  p_step [3] = '{1, 1, 3};
   int unsigned  m_o    [3];
   bit           m_tc   [3];
   bit           m_ovf  [3];

   int unsigned  n_vec = 0;
   int unsigned  n_err = 0;

   always #5 clk = ~clk;

   updown_counter #(.BUS_WIDTH(W), .SATURATE(0), .STEP(1)) u_wrap (
      .clk(clk), .rst_n(rst_n), .st(st), .X(X), .en(en), .dir(dir), .max(mx),
      .clr_ovf(clr_ovf), .o(o_q[0]), .tc(tc_q[0]), .ovf(ovf_q[0]), .zero(zero_q[0]));

   updown_counter #(.BUS_WIDTH(W), .SATURATE(1), .STEP(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .st(st), .X(X), .en(en), .dir(dir), .max(mx),
      .clr_ovf(clr_ovf), .o(o_q[1]), .tc(tc_q[1]), .ovf(ovf_q[1]), .zero(zero_q[1]));

   updown_counter #(.BUS_WIDTH(W), .SATURATE(0), .STEP(3)) u_step3 (
      .clk(clk), .rst_n(rst_n), .st(st), .X(X), .en(en), .dir(dir), .max(mx),
      .clr_ovf(clr_ovf), .o(o_q[2]), .tc(tc_q[2]), .ovf(ovf_q[2]), .zero(zero_q[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_o[k]   = 0;
         m_tc[k]  = 1'b0;
         m_ovf[k] = 1'b0;
      end
   endtask

   // Counting rules applied with plain integer arithmetic on the sampled inputs.
   task automatic model_edge(input int k);
      int unsigned lim;
      bit          bnd;
      lim = int'(mx);
      bnd = 1'b0;
      if (st) begin
         m_o[k] = (int'(X) > lim) ? lim : int'(X);
      end else if (en) begin
         if (dir) begin
            if (m_o[k] + p_step[k] <= lim) m_o[k] = m_o[k] + p_step[k];
            else begin
               bnd = 1'b1;
               m_o[k] = (p_sat[k] != 0) ? lim : 0;
            end
         end else begin
            if (m_o[k] >= p_step[k]) m_o[k] = m_o[k] - p_step[k];
            else begin
               bnd = 1'b1;
               m_o[k] = (p_sat[k] != 0) ? 0 : lim;
            end
         end
      end
      m_tc[k]  = bnd;
      m_ovf[k] = bnd ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf[k]);
   endtask

   task automatic check_all(input string ph);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s.o[%0d]", ph, k), 32'(o_q[k]), 32'(m_o[k]));
         chk($sformatf("%s.tc[%0d]", ph, k), 32'(tc_q[k]), 32'(m_tc[k]));
         chk($sformatf("%s.ovf[%0d]", ph, k), 32'(ovf_q[k]), 32'(m_ovf[k]));
         chk($sformatf("%s.zero[%0d]", ph, k), 32'(zero_q[k]), 32'(m_o[k] == 0));
      end
   endtask

   task automatic tick(input string ph);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) model_edge(k);
      check_all(ph);
   endtask

   // Called just after an edge: pulses reset well clear of any clock edge.
   task automatic pulse_reset(input string ph);
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s.rst_o[%0d]", ph, k), 32'(o_q[k]), 32'd0);
         chk($sformatf("%s.rst_tc[%0d]", ph, k), 32'(tc_q[k]), 32'd0);
         chk($sformatf("%s.rst_ovf[%0d]", ph, k), 32'(ovf_q[k]), 32'd0);
         chk($sformatf("%s.rst_zero[%0d]", ph, k), 32'(zero_q[k]), 32'd1);
      end
      rst_n = 1'b1;
   endtask

   int unsigned exp_o  [4] = '{9, 10, 10, 10};
   int unsigned exp_tc [4] = '{0, 0, 1, 1};

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      #2 check_all("reset");
      #4 rst_n = 1'b1;

      // Full up sweep in wrap mode with max = 255
      mx = 8'd255; en = 1'b1; dir = 1'b1;
      for (int i = 0; i < 256; i++) tick("sweep");
      chk("sweep.end_o", 32'(o_q[0]), 32'd0);
      chk("sweep.end_tc", 32'(tc_q[0]), 32'd1);
      chk("sweep.end_ovf", 32'(ovf_q[0]), 32'd1);

      // Saturation at max = 10 from a load of 8
      en = 1'b0; clr_ovf = 1'b1; tick("sat_clr0");
      clr_ovf = 1'b0; mx = 8'd10; st = 1'b1; X = 8'd8; tick("sat_ld");
      chk("sat.ld_o", 32'(o_q[1]), 32'd8);
      st = 1'b0; en = 1'b1; dir = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick("sat_up");
         chk($sformatf("sat.o%0d", i), 32'(o_q[1]), 32'(exp_o[i]));
         chk($sformatf("sat.tc%0d", i), 32'(tc_q[1]), 32'(exp_tc[i]));
      end
      chk("sat.ovf_set", 32'(ovf_q[1]), 32'd1);
      en = 1'b0; clr_ovf = 1'b1; tick("sat_clr");
      chk("sat.ovf_clr", 32'(ovf_q[1]), 32'd0);
      clr_ovf = 1'b0;

      // Step 3 wrapping in both directions with max = 20
      mx = 8'd20; st = 1'b1; X = 8'd19; tick("s3_ld19");
      st = 1'b0; en = 1'b1; dir = 1'b1; tick("s3_up");
      chk("s3.up_o", 32'(o_q[2]), 32'd0);
      chk("s3.up_tc", 32'(tc_q[2]), 32'd1);
      st = 1'b1; en = 1'b0; X = 8'd2; tick("s3_ld2");
      st = 1'b0; en = 1'b1; dir = 1'b0; tick("s3_dn");
      chk("s3.dn_o", 32'(o_q[2]), 32'd20);
      chk("s3.dn_tc", 32'(tc_q[2]), 32'd1);

      // Clamped load, load beats enable
      mx = 8'd100; st = 1'b1; X = 8'd200; en = 1'b1; dir = 1'b1; tick("clamp");
      chk("clamp.o", 32'(o_q[0]), 32'd100);
      chk("clamp.tc", 32'(tc_q[0]), 32'd0);

      // max lowered below the count
      mx = 8'd255; st = 1'b1; X = 8'd50; en = 1'b0; tick("mx_ld");
      st = 1'b0; mx = 8'd30; en = 1'b1; dir = 1'b1; tick("mx_up");
      chk("mx.up_wrap", 32'(o_q[0]), 32'd0);
      chk("mx.up_sat", 32'(o_q[1]), 32'd30);
      mx = 8'd255; st = 1'b1; X = 8'd50; en = 1'b0; tick("mx_ld2");
      st = 1'b0; mx = 8'd30; en = 1'b1; dir = 1'b0; tick("mx_dn");
      chk("mx.dn_o", 32'(o_q[0]), 32'd49);

      // max = 0: every enabled step is a boundary
      mx = 8'd0; dir = 1'b1; tick("m0_up");
      dir = 1'b0; tick("m0_dn");
      chk("m0.o", 32'(o_q[0]), 32'd0);
      chk("m0.tc", 32'(tc_q[0]), 32'd1);

      // Asynchronous reset mid-count with a set ovf
      mx = 8'd255; st = 1'b1; X = 8'd77; en = 1'b0; tick("ar_ld");
      chk("ar.pre_o", 32'(o_q[0]), 32'd77);
      chk("ar.pre_ovf", 32'(ovf_q[0]), 32'd1);
      st = 1'b0; en = 1'b1; dir = 1'b1;
      pulse_reset("ar");
      tick("ar_first");

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         st      = ($urandom_range(0, 9) == 0);
         en      = ($urandom_range(0, 3) != 0);
         dir     = 1'($urandom);
         X       = W'($urandom);
         clr_ovf = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 31) == 0) begin
            case ($urandom_range(0, 3))
               0:       mx = '0;
               1:       mx = '1;
               2:       mx = W'($urandom_range(0, 7));
               default: mx = W'($urandom);
            endcase
         end
         tick("rnd");
         if ($urandom_range(0, 499) == 0) pulse_reset("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
